// File: rtl/mem_responder.sv
// Data-memory responder: captures one load/store per request, inserts LATENCY wait
// states, then pulses ack (with err on illegal access). Optional MEM_RESPONDER_STATS_EN adds counters.
module mem_responder #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned LATENCY    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        err,
   output logic        busy
`ifdef MEM_RESPONDER_STATS_EN
  ,output logic [15:0] rd_count,
   output logic [15:0] wr_count,
   output logic [7:0]  err_count
`endif
);

   localparam int unsigned WORDS    = 1 << DEPTH_LOG2;
   localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   if (LATENCY > 15 || DEPTH_LOG2 < 1 || DEPTH_LOG2 > 30) begin : g_param_chk
      $error("mem_responder: LATENCY must be 0..15 and DEPTH_LOG2 1..30");
   end

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   wr_q;
   logic [31:0]            addr_q, wdata_q, rdata_q;
   logic [31:0]            mem [WORDS];
   logic [DEPTH_LOG2-1:0]  idx;
   logic                   legal;
   logic                   in_resp;

   assign idx     = addr_q[DEPTH_LOG2+1:2];
   assign legal   = (addr_q[1:0] == 2'b00) && ((addr_q >> (DEPTH_LOG2 + 2)) == 32'd0);
   assign in_resp = (state_q == RESP);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (LATENCY == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == IDLE && req) begin
            wr_q    <= wr;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         if (in_resp && !wr_q && legal) rdata_q <= mem[idx];
      end
   end

   // Storage is not reset; a reset coinciding with RESP suppresses the write.
   always_ff @(posedge clk) begin
      if (!reset && in_resp && wr_q && legal) mem[idx] <= wdata_q;
   end

   assign ack   = in_resp;
   assign err   = in_resp && !legal;
   assign busy  = (state_q != IDLE);
   // Load data is presented from the array during the ack cycle, then held in rdata_q.
   assign rdata = (in_resp && !wr_q && legal) ? mem[idx] : rdata_q;

`ifdef MEM_RESPONDER_STATS_EN
   logic [15:0] rd_count_q, wr_count_q;
   logic [7:0]  err_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_count_q  <= '0;
         wr_count_q  <= '0;
         err_count_q <= '0;
      end else if (in_resp) begin
         if (!legal)    err_count_q <= err_count_q + 8'd1;
         else if (wr_q) wr_count_q  <= wr_count_q + 16'd1;
         else           rd_count_q  <= rd_count_q + 16'd1;
      end
   end

   assign rd_count  = rd_count_q;
   assign wr_count  = wr_count_q;
   assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=2 instance (dut_a) and LATENCY=0 instance (dut_b),
// expectations from a small memory model pushed to a scoreboard and popped on ack.
module tb_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req_a, wr_a, ack_a, err_a, busy_a;
   logic [31:0] addr_a, wdata_a, rdata_a;
   logic        req_b, wr_b, ack_b, err_b, busy_b;
   logic [31:0] addr_b, wdata_b, rdata_b;
`ifdef MEM_RESPONDER_STATS_EN
   logic [15:0] rd_count_a, wr_count_a, rd_count_b, wr_count_b;
   logic [7:0]  err_count_a, err_count_b;
`endif

   mem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut_a (
      .clk(clk), .reset(reset), .req(req_a), .wr(wr_a), .addr(addr_a), .wdata(wdata_a),
      .rdata(rdata_a), .ack(ack_a), .err(err_a), .busy(busy_a)
`ifdef MEM_RESPONDER_STATS_EN
     ,.rd_count(rd_count_a), .wr_count(wr_count_a), .err_count(err_count_a)
`endif
   );

   mem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) dut_b (
      .clk(clk), .reset(reset), .req(req_b), .wr(wr_b), .addr(addr_b), .wdata(wdata_b),
      .rdata(rdata_b), .ack(ack_b), .err(err_b), .busy(busy_b)
`ifdef MEM_RESPONDER_STATS_EN
     ,.rd_count(rd_count_b), .wr_count(wr_count_b), .err_count(err_count_b)
`endif
   );

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb_a[$], sb_b[$];
   logic [31:0] mem_a [int];
   logic [31:0] mem_b [int];
   logic [31:0] rd_a, rd_b;
   int          passed = 0;
   int          total  = 0;

   function automatic logic illegal(input logic [31:0] a);
      return (a[1:0] != 2'b00) || ((a >> 12) != 32'd0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic push_a(input logic w, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.err = illegal(a);
      if (!e.err && !w) rd_a = mem_a[int'(a[11:2])];
      if (!e.err && w)  mem_a[int'(a[11:2])] = d;
      e.rdata = rd_a;
      sb_a.push_back(e);
   endtask

   task automatic push_b(input logic w, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.err = illegal(a);
      if (!e.err && !w) rd_b = mem_b[int'(a[11:2])];
      if (!e.err && w)  mem_b[int'(a[11:2])] = d;
      e.rdata = rd_b;
      sb_b.push_back(e);
   endtask

   // One request pulse on dut_a; ack must land in the 3rd cycle after the capture edge.
   task automatic txn_a(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      int   cyc;
      push_a(w, a, d);
      @(negedge clk);
      req_a = 1'b1; wr_a = w; addr_a = a; wdata_a = d;
      @(posedge clk);
      #1 req_a = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         chk({tag, " busy"}, busy_a, 1);
      end while (!ack_a && cyc < 20);
      chk({tag, " latency"}, cyc, 3);
      e = sb_a.pop_front();
      chk({tag, " err"}, err_a, e.err);
      chk({tag, " rdata"}, rdata_a, e.rdata);
      @(negedge clk);
      chk({tag, " ack low"}, ack_a, 0);
      chk({tag, " idle"}, busy_a, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      rd_a = '0; rd_b = '0;
   endtask

   logic        bw [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   logic [31:0] ba [6] = '{32'h40, 32'h44, 32'h40, 32'h44, 32'h40, 32'h44};
   logic [31:0] bd [6] = '{32'h0BADF00D, 32'h600DCAFE, 32'h0, 32'h0, 32'h0, 32'h0};

   initial begin
      exp_t e;
      reset = 1'b1;
      req_a = 1'b0; wr_a = 1'b0; addr_a = '0; wdata_a = '0;
      req_b = 1'b0; wr_b = 1'b0; addr_b = '0; wdata_b = '0;
      rd_a = '0; rd_b = '0;
      repeat (2) @(negedge clk);
      chk("rst ack", ack_a, 0);
      chk("rst err", err_a, 0);
      chk("rst busy", busy_a, 0);
      chk("rst rdata", rdata_a, 0);
      chk("rst ack b", ack_b, 0);
      chk("rst busy b", busy_b, 0);
      reset = 1'b0;

      txn_a("st10", 1'b1, 32'h10, 32'hDEADBEEF);
      txn_a("ld10", 1'b0, 32'h10, 32'h0);
      txn_a("st04", 1'b1, 32'h4, 32'hCAFEF00D);
      txn_a("st06 misaligned", 1'b1, 32'h6, 32'h11111111);
      txn_a("ld04", 1'b0, 32'h4, 32'h0);
      txn_a("ld10 again", 1'b0, 32'h10, 32'h0);
      txn_a("ld1000 oob", 1'b0, 32'h1000, 32'h0);
      txn_a("ld40000000 oob", 1'b0, 32'h40000000, 32'h0);

      // LATENCY=0 with req held high: ack every second cycle, RESP-cycle inputs ignored.
      @(negedge clk);
      req_b = 1'b1; wr_b = bw[0]; addr_b = ba[0]; wdata_b = bd[0];
      push_b(bw[0], ba[0], bd[0]);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("b%0d ack", i), ack_b, 1);
         e = sb_b.pop_front();
         chk($sformatf("b%0d err", i), err_b, e.err);
         chk($sformatf("b%0d rdata", i), rdata_b, e.rdata);
         if (i < 5) begin
            wr_b = bw[i+1]; addr_b = ba[i+1]; wdata_b = bd[i+1];
            push_b(bw[i+1], ba[i+1], bd[i+1]);
         end else begin
            req_b = 1'b0;
         end
         @(negedge clk);
         chk($sformatf("b%0d ack gap", i), ack_b, 0);
         chk($sformatf("b%0d idle gap", i), busy_b, 0);
      end

      // Reset during the RESP cycle of a store aborts it.
      txn_a("st20 pre", 1'b1, 32'h20, 32'hAAAA5555);
      @(negedge clk);
      req_a = 1'b1; wr_a = 1'b1; addr_a = 32'h20; wdata_a = 32'h12345678;
      @(posedge clk);
      #1 req_a = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("abort in resp busy", busy_a, 1);
      @(negedge clk);
      chk("abort ack", ack_a, 0);
      chk("abort err", err_a, 0);
      chk("abort busy", busy_a, 0);
      chk("abort rdata", rdata_a, 0);
      reset = 1'b0;
      rd_a = '0; rd_b = '0;
      txn_a("ld20 after abort", 1'b0, 32'h20, 32'h0);

`ifdef MEM_RESPONDER_STATS_EN
      do_reset();
      txn_a("s st10", 1'b1, 32'h10, 32'h01010101);
      txn_a("s st14", 1'b1, 32'h14, 32'h02020202);
      txn_a("s ld10", 1'b0, 32'h10, 32'h0);
      txn_a("s ld14", 1'b0, 32'h14, 32'h0);
      txn_a("s ld10b", 1'b0, 32'h10, 32'h0);
      txn_a("s ld03", 1'b0, 32'h3, 32'h0);
      chk("rd_count", rd_count_a, 3);
      chk("wr_count", wr_count_a, 2);
      chk("err_count", err_count_a, 1);
      do_reset();
      chk("rd_count rst", rd_count_a, 0);
      chk("wr_count rst", wr_count_a, 0);
      chk("err_count rst", err_count_a, 0);
`else
      do_reset();
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
